// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and frame-sequencer states,
// common to the transmitter and the matching receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick on the last enabled cycle of each bit period.
// restart holds the count at zero so the first period after it is full length.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic CLKIN,
  input  logic RESETN,
  input  logic clock_enable,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = clock_enable && !restart && (cnt == LAST);

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      cnt <= '0;
    end else if (clock_enable) begin
      if (restart || tick) cnt <= '0;
      else                 cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-entry holding register so
// back-to-back words go out with no idle gap between frames.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter parity_e     PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                 CLKIN,
  input  logic                 RESETN,
  input  logic                 clock_enable,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned     BW        = $clog2(DATA_BITS);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic            LAST_STOP = (STOP_BITS == 2);

  uart_state_e          state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, hold, hold_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic                 stop_cnt, stop_n;
  logic                 par_q, par_n;
  logic                 ready_n, tx_n;
  logic                 tick, accept, restart, consumed;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (^w) ^ (PARITY == PARITY_ODD);
  endfunction

  assign accept  = valid && ready && clock_enable;
  assign restart = (state == IDLE);
  assign busy    = (state != IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLKIN       (CLKIN),
    .RESETN      (RESETN),
    .clock_enable(clock_enable),
    .restart     (restart),
    .tick        (tick)
  );

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    hold_n   = hold;
    bit_n    = bit_cnt;
    stop_n   = stop_cnt;
    par_n    = par_q;
    ready_n  = ready;
    consumed = 1'b0;
    tx_n     = 1'b1;
    case (state)
      IDLE: if (accept) begin
        shreg_n  = data;
        par_n    = parity_of(data);
        state_n  = START;
        consumed = 1'b1;
      end
      START: if (tick) begin
        state_n = DATA;
        bit_n   = '0;
      end
      DATA: if (tick) begin
        if (bit_cnt == LAST_BIT) begin
          state_n = (PARITY == PARITY_NONE) ? STOP : PAR;
          stop_n  = 1'b0;
        end else begin
          bit_n   = bit_cnt + BW'(1);
          shreg_n = shreg >> 1;
        end
      end
      PAR: if (tick) begin
        state_n = STOP;
        stop_n  = 1'b0;
      end
      STOP: if (tick) begin
        if (stop_cnt == LAST_STOP) begin
          // Held word wins; otherwise a word offered on this very edge starts directly.
          if (!ready) begin
            shreg_n = hold;
            par_n   = parity_of(hold);
            ready_n = 1'b1;
            state_n = START;
          end else if (accept) begin
            shreg_n  = data;
            par_n    = parity_of(data);
            state_n  = START;
            consumed = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          stop_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (accept && !consumed) begin
      hold_n  = data;
      ready_n = 1'b0;
    end
    // tx is registered from the next-state view so each bit appears on the edge that enters it.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PAR:     tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      shreg    <= '0;
      hold     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_q    <= 1'b0;
      ready    <= 1'b1;
      tx       <= 1'b1;
    end else if (clock_enable) begin
      state    <= state_n;
      shreg    <= shreg_n;
      hold     <= hold_n;
      bit_cnt  <= bit_n;
      stop_cnt <= stop_n;
      par_q    <= par_n;
      ready    <= ready_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations checked every cycle against a
// line-level queue model, plus literal waveform expectations.
module tb_uart_tx_param;

  typedef bit bitq_t[$];

  localparam int M_DB  [3] = '{8, 8, 7};
  localparam int M_PM  [3] = '{2, 1, 0};   // 0 none, 1 odd, 2 even
  localparam int M_SB  [3] = '{1, 1, 2};
  localparam int M_CPB [3] = '{4, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ce = 1'b1;
  logic [8:0] data_i  [3] = '{9'h0, 9'h0, 9'h0};
  logic       valid_i [3] = '{1'b0, 1'b0, 1'b0};
  logic       tx_o    [3];
  logic       rdy_o   [3];
  logic       busy_o  [3];

  int checks = 0;
  int errors = 0;

  bitq_t lq [3];
  bit    m_ready  [3] = '{1'b1, 1'b1, 1'b1};
  bit    m_held_v [3] = '{1'b0, 1'b0, 1'b0};
  int    m_held   [3] = '{0, 0, 0};

  logic cap_tx [128];
  logic cap_rdy [128];
  logic cap_busy [128];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .PARITY(uart_pkg::PARITY_EVEN), .STOP_BITS(1), .CLKS_PER_BIT(4)) u_even (
    .CLKIN(clk), .RESETN(rst_n), .clock_enable(ce), .data(data_i[0][7:0]), .valid(valid_i[0]),
    .ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(uart_pkg::PARITY_ODD), .STOP_BITS(1), .CLKS_PER_BIT(2)) u_odd (
    .CLKIN(clk), .RESETN(rst_n), .clock_enable(ce), .data(data_i[1][7:0]), .valid(valid_i[1]),
    .ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]));
  uart_tx_param #(.DATA_BITS(7), .PARITY(uart_pkg::PARITY_NONE), .STOP_BITS(2), .CLKS_PER_BIT(1)) u_none (
    .CLKIN(clk), .RESETN(rst_n), .clock_enable(ce), .data(data_i[2][6:0]), .valid(valid_i[2]),
    .ready(rdy_o[2]), .tx(tx_o[2]), .busy(busy_o[2]));

  // One entry per enabled cycle of line level.
  function automatic bitq_t frame(input int db, input int pm, input int sb, input int cpb, input int w);
    bitq_t q;
    int lv[$];
    int p;
    p = 0;
    lv.push_back(0);
    for (int k = 0; k < db; k++) begin
      lv.push_back((w >> k) & 1);
      p ^= (w >> k) & 1;
    end
    if (pm == 1) lv.push_back(p ^ 1);
    else if (pm == 2) lv.push_back(p);
    for (int k = 0; k < sb; k++) lv.push_back(1);
    foreach (lv[j]) for (int c = 0; c < cpb; c++) q.push_back(bit'(lv[j]));
    return q;
  endfunction

  function automatic void push_frame(input int i, input int w);
    bitq_t f;
    f = frame(M_DB[i], M_PM[i], M_SB[i], M_CPB[i], w);
    foreach (f[j]) lq[i].push_back(f[j]);
  endfunction

  function automatic void model_step(input int i);
    bit acc;
    acc = valid_i[i] && m_ready[i];
    if (lq[i].size() != 0) void'(lq[i].pop_front());
    if (lq[i].size() == 0 && m_held_v[i]) begin
      push_frame(i, m_held[i]);
      m_held_v[i] = 1'b0;
      m_ready[i]  = 1'b1;
    end
    if (acc) begin
      if (lq[i].size() == 0) push_frame(i, int'(data_i[i]));
      else begin
        m_held[i]   = int'(data_i[i]);
        m_held_v[i] = 1'b1;
        m_ready[i]  = 1'b0;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        lq[i].delete();
        m_held_v[i] = 1'b0;
        m_ready[i]  = 1'b1;
      end
    end else if (ce) begin
      for (int i = 0; i < 3; i++) model_step(i);
    end
  end

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %b, expected %b (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check("model_tx", i, tx_o[i], (lq[i].size() != 0) ? lq[i][0] : 1'b1);
      check("model_ready", i, rdy_o[i], m_ready[i]);
      check("model_busy", i, busy_o[i], lq[i].size() != 0);
    end
  end

  // Offers w1 (and optionally w2 right behind it) and records n enabled-cycle samples.
  task automatic capture(input int i, input int n, input bit toggle, input bit two,
                         input logic [8:0] w1, input logic [8:0] w2);
    int k = 0;
    int guard = 0;
    data_i[i]  = w1;
    valid_i[i] = 1'b1;
    ce = 1'b1;
    while (k < n && guard < 400) begin
      @(negedge clk);
      guard++;
      if (ce) begin
        cap_tx[k]   = tx_o[i];
        cap_rdy[k]  = rdy_o[i];
        cap_busy[k] = busy_o[i];
        k++;
      end
      if (two && k == 1) data_i[i] = w2;
      else valid_i[i] = 1'b0;
      if (toggle) ce = ~ce;
    end
    ce = 1'b1;
    valid_i[i] = 1'b0;
    check("capture_timeout", i, k >= n, 1'b1);
  endtask

  task automatic wait_idle(input int i);
    int g = 0;
    while ((lq[i].size() != 0 || m_held_v[i]) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("idle_timeout", i, g < 500, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    lit_a5 [11];
    bit    lit_55 [10];
    bitq_t fq;

    lit_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    lit_55 = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1};

    // Pin the model against hand-computed frames.
    fq = frame(8, 2, 1, 4, 'hA5);
    check("model_a5_len", 0, fq.size() == 44, 1'b1);
    for (int k = 0; k < 44 && k < fq.size(); k++) check("model_a5", k, fq[k], lit_a5[k / 4]);
    fq = frame(8, 1, 1, 2, 'h01);
    check("model_odd01_par", 0, fq[18], 1'b0);
    fq = frame(8, 1, 1, 2, 'h00);
    check("model_odd00_par", 0, fq[18], 1'b1);
    fq = frame(7, 0, 2, 1, 'h55);
    check("model_55_len", 0, fq.size() == 10, 1'b1);
    for (int k = 0; k < 10 && k < fq.size(); k++) check("model_55", k, fq[k], lit_55[k]);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_tx", i, tx_o[i], 1'b1);
      check("reset_ready", i, rdy_o[i], 1'b1);
      check("reset_busy", i, busy_o[i], 1'b0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8E1, 4 clocks/bit, 0xA5
    capture(0, 44, 1'b0, 1'b0, 9'hA5, 9'h0);
    for (int k = 0; k < 44; k++) check("a5_wave", k, cap_tx[k], lit_a5[k / 4]);
    @(negedge clk);
    check("a5_end_busy", 0, busy_o[0], 1'b0);
    check("a5_end_tx", 0, tx_o[0], 1'b1);
    wait_idle(0);

    // 8O1 parity bit
    capture(1, 22, 1'b0, 1'b0, 9'h01, 9'h0);
    check("odd01_par", 1, cap_tx[18], 1'b0);
    wait_idle(1);
    capture(1, 22, 1'b0, 1'b0, 9'h00, 9'h0);
    check("odd00_par", 1, cap_tx[18], 1'b1);
    wait_idle(1);

    // 7N2, 1 clock/bit, 0x55
    capture(2, 10, 1'b0, 1'b0, 9'h55, 9'h0);
    for (int k = 0; k < 10; k++) check("n2_wave", k, cap_tx[k], lit_55[k]);
    wait_idle(2);

    // Accept landing on the last stop-bit cycle with nothing held
    data_i[2] = 9'h55;
    valid_i[2] = 1'b1;
    @(negedge clk);
    valid_i[2] = 1'b0;
    repeat (9) @(negedge clk);
    check("last_stop_tx", 2, tx_o[2], 1'b1);
    data_i[2] = 9'h0F;
    valid_i[2] = 1'b1;
    @(negedge clk);
    valid_i[2] = 1'b0;
    check("direct_start_tx", 2, tx_o[2], 1'b0);
    check("direct_start_ready", 2, rdy_o[2], 1'b1);
    check("direct_start_busy", 2, busy_o[2], 1'b1);
    wait_idle(2);

    // Back-to-back 0x00 then 0xFF with valid held
    capture(0, 88, 1'b0, 1'b1, 9'h00, 9'hFF);
    check("b2b_ready_after_hold", 1, cap_rdy[1], 1'b0);
    check("b2b_ready_last_stop", 43, cap_rdy[43], 1'b0);
    check("b2b_ready_reraised", 44, cap_rdy[44], 1'b1);
    check("b2b_par0", 39, cap_tx[39], 1'b0);
    check("b2b_stop0", 43, cap_tx[43], 1'b1);
    check("b2b_start1", 44, cap_tx[44], 1'b0);
    check("b2b_data1", 48, cap_tx[48], 1'b1);
    check("b2b_par1", 80, cap_tx[80], 1'b0);
    check("b2b_stop1", 84, cap_tx[84], 1'b1);
    for (int k = 0; k < 88; k++) check("b2b_contig_busy", k, cap_busy[k], 1'b1);
    wait_idle(0);

    // clock_enable toggling: same waveform in enabled cycles
    capture(0, 44, 1'b1, 1'b0, 9'hA5, 9'h0);
    for (int k = 0; k < 44; k++) check("ce_wave", k, cap_tx[k], lit_a5[k / 4]);
    wait_idle(0);

    // Reset during data bit 3
    capture(0, 17, 1'b0, 1'b0, 9'hA5, 9'h0);
    check("pre_reset_bit3", 16, cap_tx[16], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("reset_now_tx", 0, tx_o[0], 1'b1);
    check("reset_now_ready", 0, rdy_o[0], 1'b1);
    check("reset_now_busy", 0, busy_o[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("post_reset_tx", k, tx_o[0], 1'b1);
      check("post_reset_busy", k, busy_o[0], 1'b0);
    end
    capture(0, 44, 1'b0, 1'b0, 9'h3C, 9'h0);
    check("after_reset_start", 0, cap_tx[0], 1'b0);
    check("after_reset_b0", 4, cap_tx[4], 1'b0);
    check("after_reset_b2", 12, cap_tx[12], 1'b1);
    wait_idle(0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
